// File: rtl/bs_dev_pkg.sv
// rtl/bs_dev_pkg.sv - shared state encoding, terminator codes and defaults for the hex parser
package bs_dev_pkg;

  localparam int MAX_DIGITS_DEF = 8;

  localparam logic [7:0] CH_SP = 8'h20;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  function automatic logic is_term(input logic [7:0] c);
    return (c == CH_SP) || (c == CH_CR) || (c == CH_LF);
  endfunction

endpackage

// File: rtl/bs_dev_hex_parser_if.sv
// rtl/bs_dev_hex_parser_if.sv - character input and number output handshakes of the hex parser
interface bs_dev_hex_parser_if
  import bs_dev_pkg::*;
#(
  parameter int MAX_DIGITS = MAX_DIGITS_DEF
);
  logic [7:0]              ascii;
  logic                    ascii_vld;
  logic                    ascii_rdy;
  logic [4*MAX_DIGITS-1:0] value;
  logic [3:0]              digits;
  logic                    value_vld;
  logic                    value_rdy;
  logic                    err;

  modport master (
    output ascii, ascii_vld, value_rdy,
    input  ascii_rdy, value, digits, value_vld, err
  );

  modport slave (
    input  ascii, ascii_vld, value_rdy,
    output ascii_rdy, value, digits, value_vld, err
  );
endinterface

// File: rtl/bs_dev_ascii_hex.sv
// rtl/bs_dev_ascii_hex.sv - flags and decodes the 22 ASCII hex characters into a nibble
module bs_dev_ascii_hex (
  input  logic [7:0] ascii,
  output logic       is_hex,
  output logic [3:0] nibble
);

  always_comb begin
    is_hex = 1'b1;
    nibble = 4'd0;
    if (ascii >= 8'h30 && ascii <= 8'h39) begin
      nibble = ascii[3:0];
    end else if ((ascii >= 8'h41 && ascii <= 8'h46) || (ascii >= 8'h61 && ascii <= 8'h66)) begin
      // 'A'/'a' have low nibble 1, so adding 9 maps A..F onto 10..15
      nibble = ascii[3:0] + 4'd9;
    end else begin
      is_hex = 1'b0;
    end
  end

endmodule

// File: rtl/bs_dev_hex_parser.sv
// rtl/bs_dev_hex_parser.sv - assembles whitespace/CR/LF-terminated ASCII hex numbers into values
module bs_dev_hex_parser
  import bs_dev_pkg::*;
#(
  parameter int MAX_DIGITS = MAX_DIGITS_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  bs_dev_hex_parser_if.slave  bus
);

  localparam int W = 4 * MAX_DIGITS;

  state_t         state_q, state_d;
  logic [W-1:0]   acc_q, acc_d;
  logic [3:0]     cnt_q, cnt_d;
  logic           err_q, err_d;
  logic           rdy_q, rdy_d;
  logic           vld_q, vld_d;
  logic [W-1:0]   value_q, value_d;
  logic [3:0]     digits_q, digits_d;

  logic           is_hex;
  logic [3:0]     nibble;
  logic           accept;

  bs_dev_ascii_hex u_dec (
    .ascii  (bus.ascii),
    .is_hex (is_hex),
    .nibble (nibble)
  );

  assign accept = bus.ascii_vld && rdy_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE, S_ACCUM: begin
        if (accept) begin
          if (is_hex) begin
            if (cnt_q == 4'(MAX_DIGITS)) begin
              err_d   = 1'b1;
              acc_d   = '0;
              cnt_d   = 4'd0;
              state_d = S_IDLE;
            end else begin
              acc_d   = (acc_q << 4) | W'(nibble);
              cnt_d   = cnt_q + 4'd1;
              state_d = S_ACCUM;
            end
          end else if (is_term(bus.ascii)) begin
            // separators before any digit are simply skipped
            if (state_q == S_ACCUM) state_d = S_DONE;
          end else begin
            err_d   = 1'b1;
            acc_d   = '0;
            cnt_d   = 4'd0;
            state_d = S_IDLE;
          end
        end
      end
      S_DONE: begin
        if (bus.value_rdy) begin
          acc_d   = '0;
          cnt_d   = 4'd0;
          state_d = S_IDLE;
        end
      end
      default: begin
        acc_d   = '0;
        cnt_d   = 4'd0;
        state_d = S_IDLE;
      end
    endcase

    rdy_d    = (state_d != S_DONE);
    vld_d    = (state_d == S_DONE);
    value_d  = vld_d ? acc_d : '0;
    digits_d = vld_d ? cnt_d : 4'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      cnt_q    <= 4'd0;
      err_q    <= 1'b0;
      rdy_q    <= 1'b0;
      vld_q    <= 1'b0;
      value_q  <= '0;
      digits_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      rdy_q    <= rdy_d;
      vld_q    <= vld_d;
      value_q  <= value_d;
      digits_q <= digits_d;
    end
  end

  assign bus.ascii_rdy = rdy_q;
  assign bus.value_vld = vld_q;
  assign bus.value     = value_q;
  assign bus.digits    = digits_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_bs_dev_hex_parser.sv
// tb/tb_bs_dev_hex_parser.sv - table-driven and directed checks of the ASCII hex parser
module tb_bs_dev_hex_parser;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bs_dev_hex_parser_if #(.MAX_DIGITS(8)) bus ();

  bs_dev_hex_parser #(.MAX_DIGITS(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [7:0]  ch;
    logic        e_err;
    logic        e_vld;
    logic [31:0] e_val;
    logic [3:0]  e_dig;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic addv(input logic [7:0] ch, input logic e_err, input logic e_vld,
                      input logic [31:0] e_val, input logic [3:0] e_dig);
    vec_t v;
    v.ch = ch; v.e_err = e_err; v.e_vld = e_vld; v.e_val = e_val; v.e_dig = e_dig;
    vecs.push_back(v);
  endtask

  task automatic add_str(input string s);
    for (int i = 0; i < s.len(); i++) addv(s[i], 1'b0, 1'b0, 32'h0, 4'd0);
  endtask

  task automatic drive(input logic [7:0] ch, input logic v);
    @(negedge clk);
    bus.ascii     = ch;
    bus.ascii_vld = v;
    @(posedge clk);
    #1;
    bus.ascii_vld = 1'b0;
  endtask

  task automatic chk_out(input string nm, input logic [31:0] val, input logic [3:0] dig);
    chk({nm, "_vld"}, 32'(bus.value_vld), 32'd1);
    chk({nm, "_val"}, bus.value, val);
    chk({nm, "_dig"}, 32'(bus.digits), 32'(dig));
    chk({nm, "_rdy"}, 32'(bus.ascii_rdy), 32'd0);
    chk({nm, "_err"}, 32'(bus.err), 32'd0);
  endtask

  task automatic consume(input string nm);
    @(negedge clk);
    bus.value_rdy = 1'b1;
    @(posedge clk);
    #1;
    bus.value_rdy = 1'b0;
    chk({nm, "_clr_vld"}, 32'(bus.value_vld), 32'd0);
    chk({nm, "_clr_rdy"}, 32'(bus.ascii_rdy), 32'd1);
    chk({nm, "_clr_dig"}, 32'(bus.digits), 32'd0);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.ascii     = 8'h00;
    bus.ascii_vld = 1'b0;
    bus.value_rdy = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdy", 32'(bus.ascii_rdy), 32'd0);
    chk("rst_vld", 32'(bus.value_vld), 32'd0);
    chk("rst_val", bus.value, 32'h0);
    chk("rst_dig", 32'(bus.digits), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rdy_after_rst", 32'(bus.ascii_rdy), 32'd1);

    add_str("1A3f");     addv(8'h0D, 1'b0, 1'b1, 32'h00001A3F, 4'd4);
    add_str("7");        addv("G",   1'b1, 1'b0, 32'h0, 4'd0);
    add_str("5");        addv(8'h0A, 1'b0, 1'b1, 32'h5, 4'd1);
    add_str("12345678"); addv("9",   1'b1, 1'b0, 32'h0, 4'd0);
    add_str("2");        addv(8'h20, 1'b0, 1'b1, 32'h2, 4'd1);
    add_str("FFFFFFFF"); addv(8'h0D, 1'b0, 1'b1, 32'hFFFFFFFF, 4'd8);
    addv(8'h20, 1'b0, 1'b0, 32'h0, 4'd0);
    addv(8'h20, 1'b0, 1'b0, 32'h0, 4'd0);
    addv(8'h0D, 1'b0, 1'b0, 32'h0, 4'd0);
    add_str("abcdef09"); addv(8'h20, 1'b0, 1'b1, 32'hABCDEF09, 4'd8);
    addv("/", 1'b1, 1'b0, 32'h0, 4'd0);
    add_str("9");        addv(":", 1'b1, 1'b0, 32'h0, 4'd0);
    addv("@", 1'b1, 1'b0, 32'h0, 4'd0);
    addv(8'h60, 1'b1, 1'b0, 32'h0, 4'd0);
    add_str("c");        addv("g", 1'b1, 1'b0, 32'h0, 4'd0);
    add_str("0");        addv(8'h0D, 1'b0, 1'b1, 32'h0, 4'd1);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].ch, 1'b1);
      chk($sformatf("v%0d_err", i), 32'(bus.err), 32'(vecs[i].e_err));
      chk($sformatf("v%0d_vld", i), 32'(bus.value_vld), 32'(vecs[i].e_vld));
      chk($sformatf("v%0d_rdy", i), 32'(bus.ascii_rdy), 32'(!vecs[i].e_vld));
      chk($sformatf("v%0d_dig", i), 32'(bus.digits), 32'(vecs[i].e_dig));
      if (vecs[i].e_vld) begin
        chk($sformatf("v%0d_val", i), bus.value, vecs[i].e_val);
        consume($sformatf("v%0d", i));
      end
    end

    drive("1", 1'b1);
    drive("2", 1'b1);
    drive(8'h20, 1'b1);
    chk_out("hold0", 32'h12, 4'd2);
    for (int k = 1; k <= 5; k++) begin
      drive("3", 1'b1);
      chk_out($sformatf("hold%0d", k), 32'h12, 4'd2);
    end
    consume("hold");
    drive(8'h0D, 1'b1);
    chk("hold_no_leak", 32'(bus.value_vld), 32'd0);

    bus.value_rdy = 1'b1;
    drive("4", 1'b1);
    repeat (3) drive("7", 1'b0);
    drive("2", 1'b1);
    drive("9", 1'b0);
    bus.value_rdy = 1'b0;
    drive(8'h0D, 1'b1);
    chk_out("gap", 32'h42, 4'd2);
    consume("gap");

    drive("A", 1'b1);
    drive("B", 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst1_rdy", 32'(bus.ascii_rdy), 32'd0);
    chk("arst1_vld", 32'(bus.value_vld), 32'd0);
    chk("arst1_err", 32'(bus.err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive("C", 1'b1);
    drive(8'h0D, 1'b1);
    chk_out("arst1_after", 32'hC, 4'd1);
    consume("arst1");

    drive("1", 1'b1);
    drive("2", 1'b1);
    drive(8'h20, 1'b1);
    chk_out("arst2_pre", 32'h12, 4'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst2_rdy", 32'(bus.ascii_rdy), 32'd0);
    chk("arst2_vld", 32'(bus.value_vld), 32'd0);
    chk("arst2_val", bus.value, 32'h0);
    chk("arst2_dig", 32'(bus.digits), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive("C", 1'b1);
    drive(8'h0D, 1'b1);
    chk_out("arst2_after", 32'hC, 4'd1);
    consume("arst2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  always @(negedge clk) begin
    if (rst_n && bus.err && bus.value_vld) begin
      errors++;
      $display("FAIL err_with_vld: got err=1 vld=1 expected not both");
    end
  end

endmodule

// File: doc/bs_dev_hex_parser.md
BS_DEV_HEX_PARSER -- requirements
Module: bs_dev_hex_parser

Interface
REQ-001 SHALL provide parameter: MAX_DIGITS, 8, maximum hex digits per number (1..8).
REQ-002 SHALL provide port: CLK  input  1  single system clock, all state updates on rising edge.
REQ-003 SHALL provide port: RST_N  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide port: ASCII  input  8  incoming character byte.
REQ-005 SHALL provide port: ASCII_VLD  input  1  ASCII holds a valid character this cycle.
REQ-006 SHALL provide port: ASCII_RDY  output  1  parser can accept a character this cycle.
REQ-007 SHALL provide port: VALUE  output  4*MAX_DIGITS  assembled number, right-justified.
REQ-008 SHALL provide port: DIGITS  output  4  number of digits in VALUE.
REQ-009 SHALL provide port: VALUE_VLD  output  1  VALUE/DIGITS valid, held until consumed.
REQ-010 SHALL provide port: VALUE_RDY  input  1  consumer accepts VALUE this cycle.
REQ-011 SHALL provide port: ERR  output  1  one-cycle pulse: bad character or digit overflow.

Function
REQ-012 SHALL treat a character as accepted only when ASCII_VLD=1 and ASCII_RDY=1 on a rising CLK edge.
REQ-013 SHALL classify each accepted byte as: hex digit (0x30-0x39, 0x41-0x46, 0x61-0x66), terminator (0x20, 0x0D, 0x0A), or illegal (all others).
REQ-014 SHALL implement states IDLE, ACCUM, DONE, with IDLE as reset state.
REQ-015 SHALL in IDLE and ACCUM drive ASCII_RDY=1, VALUE_VLD=0.
REQ-016 SHALL, on accepted hex digit with count<MAX_DIGITS: acc <= {acc[4*MAX_DIGITS-5:0], nibble}, count+1, state ACCUM.
REQ-017 SHALL, on accepted hex digit with count==MAX_DIGITS: pulse ERR next cycle, clear acc and count, state IDLE.
REQ-018 SHALL, on accepted illegal byte in IDLE or ACCUM: pulse ERR next cycle, clear acc and count, state IDLE.
REQ-019 SHALL, on accepted terminator in ACCUM: state DONE, VALUE_VLD=1 from the next cycle (latency 1 clock).
REQ-020 SHALL ignore an accepted terminator in IDLE (no ERR, no VALUE_VLD, stay IDLE); leading/repeated separators are legal.
REQ-021 SHALL in DONE drive ASCII_RDY=0, VALUE_VLD=1, VALUE=acc, DIGITS=count, all stable until VALUE_RDY=1.
REQ-022 SHALL, on VALUE_RDY=1 in DONE: clear acc and count, state IDLE, ASCII_RDY=1 the following cycle.
REQ-023 SHALL ignore VALUE_RDY outside DONE.
REQ-024 SHALL keep unused upper VALUE bits zero (no sign extension); DIGITS=0 whenever VALUE_VLD=0.
REQ-025 SHALL never assert ERR and VALUE_VLD in the same cycle.

Reset
REQ-026 SHALL on RST_N=0, asynchronously and regardless of state: state IDLE, acc=0, count=0, VALUE=0, DIGITS=0, VALUE_VLD=0, ERR=0, ASCII_RDY=0 while asserted.
REQ-027 SHALL drive ASCII_RDY=1 from the first rising CLK edge after RST_N deasserts; a partial number or pending VALUE at reset is discarded.

Structure
REQ-028 SHALL place state encoding, terminator codes (0x20, 0x0D, 0x0A) and MAX_DIGITS default in shared package bs_dev_pkg.
REQ-029 SHALL instantiate one BS_DEV_ASCII_HEX for digit decode, which SHALL flag and decode all 22 hex characters (0-9, A-F, a-f).
REQ-030 SHALL implement terminator detection, FSM, accumulator and counter in bs_dev_hex_parser itself.

Verification
REQ-031 SHALL check: "1A3f" then 0x0D, VALUE_RDY=1 -> VALUE=0x00001A3F, DIGITS=4, VALUE_VLD one cycle after 0x0D, then IDLE.
REQ-032 SHALL check: "12" 0x20, VALUE_RDY held 0 for 5 cycles -> VALUE=0x12 stable, ASCII_RDY=0 throughout, clears after VALUE_RDY=1.
REQ-033 SHALL check: "7G" -> ERR pulse 1 cycle after 'G', no VALUE_VLD; following "5" 0x0A -> VALUE=0x5, DIGITS=1.
REQ-034 SHALL check: "123456789" (MAX_DIGITS=8) -> ERR on 9th digit, acc cleared; "FFFFFFFF" 0x0D -> VALUE=0xFFFFFFFF, DIGITS=8.
REQ-035 SHALL check: 0x20 0x20 0x0D in IDLE -> no ERR, no VALUE_VLD; ASCII_VLD=0 gaps mid-number do not alter result.
REQ-036 SHALL check: RST_N pulsed low after "AB" and again while in DONE -> all outputs 0 immediately, next "C" 0x0D yields VALUE=0xC.
